// File: rtl/sha2_message_schedule_stream.sv
// SHA-2 message-schedule engine: loads one 16-word block, then streams W_0..W_{ROUNDS-1}
// with round index and last flag. Valid/ready on both sides, block abort via clear_i.
module sha2_message_schedule_stream #(
    parameter int MODE = 256,
    localparam int WIDTH  = ((MODE == 384) || (MODE == 512)) ? 64 : 32,
    localparam int ROUNDS = (WIDTH == 64) ? 80 : 64,
    localparam int RW     = $clog2(ROUNDS)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [RW-1:0]    out_round_o,
    output logic             out_last_o
);

    // state   | meaning
    // ST_LOAD | accepting message words W_0..W_15, cnt = words taken so far
    // ST_EMIT | presenting W_cnt from M[0], expanding one word per handshake
    typedef enum logic {ST_LOAD, ST_EMIT} state_t;

    if (!((MODE == 224) || (MODE == 256) || (MODE == 384) || (MODE == 512))) begin : g_bad_mode
        $error("sha2_message_schedule_stream: MODE must be 224, 256, 384 or 512");
    end

    localparam int unsigned S0_R1 = (WIDTH == 64) ? 1  : 7;
    localparam int unsigned S0_R2 = (WIDTH == 64) ? 8  : 18;
    localparam int unsigned S0_SH = (WIDTH == 64) ? 7  : 3;
    localparam int unsigned S1_R1 = (WIDTH == 64) ? 19 : 17;
    localparam int unsigned S1_R2 = (WIDTH == 64) ? 61 : 19;
    localparam int unsigned S1_SH = (WIDTH == 64) ? 6  : 10;

    localparam logic [RW-1:0] CNT_LOAD_LAST = RW'(15);
    localparam logic [RW-1:0] CNT_EMIT_LAST = RW'(ROUNDS - 1);

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WIDTH - n));
    endfunction

    state_t           state_q, state_d;
    logic [RW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] m_q [16];

    logic             shift_en;
    logic [WIDTH-1:0] ins_word;
    logic [WIDTH-1:0] sig0, sig1, new_word;

    // The window is arranged so the recurrence taps are fixed positions: W_{t-16}, W_{t-15},
    // W_{t-7} and W_{t-2} always sit in M[0], M[1], M[9] and M[14].
    assign sig0     = rotr(m_q[1], S0_R1) ^ rotr(m_q[1], S0_R2) ^ (m_q[1] >> S0_SH);
    assign sig1     = rotr(m_q[14], S1_R1) ^ rotr(m_q[14], S1_R2) ^ (m_q[14] >> S1_SH);
    assign new_word = m_q[0] + sig0 + m_q[9] + sig1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_en = 1'b0;
        ins_word = in_data_i;
        if (clear_i) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (in_valid_i) begin
                        shift_en = 1'b1;
                        ins_word = in_data_i;
                        if (cnt_q == CNT_LOAD_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_EMIT;
                        end else begin
                            cnt_d = cnt_q + RW'(1);
                        end
                    end
                end
                ST_EMIT: begin
                    if (out_ready_i) begin
                        shift_en = 1'b1;
                        ins_word = new_word;
                        if (cnt_q == CNT_EMIT_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_LOAD;
                        end else begin
                            cnt_d = cnt_q + RW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < 16; i++) begin
                m_q[i] <= '0;
            end
        end else if (shift_en) begin
            for (int i = 0; i < 15; i++) begin
                m_q[i] <= m_q[i+1];
            end
            m_q[15] <= ins_word;
        end
    end

    // All outputs come from registers only; no path from in_valid_i/out_ready_i.
    assign in_ready_o  = (state_q == ST_LOAD);
    assign out_valid_o = (state_q == ST_EMIT);
    assign out_data_o  = m_q[0];
    assign out_round_o = (state_q == ST_EMIT) ? cnt_q : '0;
    assign out_last_o  = (state_q == ST_EMIT) && (cnt_q == CNT_EMIT_LAST);

endmodule

// File: tb/tb_sha2_message_schedule_stream.sv
// Bench for sha2_message_schedule_stream: one instance per MODE, scoreboard of expected
// schedule words filled as blocks are accepted, compared as the DUT emits them.
module tb_sha2_message_schedule_stream;

    typedef struct packed {
        logic [63:0] d;
        logic [6:0]  r;
        logic        l;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        clear;
    logic        in_valid  [4];
    logic        out_ready [4];
    logic [63:0] in_data   [4];

    logic        in_ready_w  [4];
    logic        out_valid_w [4];
    logic        out_last_w  [4];
    logic [63:0] out_data_w  [4];
    logic [6:0]  out_round_w [4];

    logic        ir0, ir1, ir2, ir3, ov0, ov1, ov2, ov3, ol0, ol1, ol2, ol3;
    logic [31:0] od0, od1;
    logic [63:0] od2, od3;
    logic [5:0]  or0, or1;
    logic [6:0]  or2, or3;

    sha2_message_schedule_stream #(.MODE(224)) u_224 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .in_valid_i(in_valid[0]), .in_ready_o(ir0), .in_data_i(in_data[0][31:0]),
        .out_valid_o(ov0), .out_ready_i(out_ready[0]), .out_data_o(od0),
        .out_round_o(or0), .out_last_o(ol0));
    sha2_message_schedule_stream #(.MODE(256)) u_256 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .in_valid_i(in_valid[1]), .in_ready_o(ir1), .in_data_i(in_data[1][31:0]),
        .out_valid_o(ov1), .out_ready_i(out_ready[1]), .out_data_o(od1),
        .out_round_o(or1), .out_last_o(ol1));
    sha2_message_schedule_stream #(.MODE(384)) u_384 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .in_valid_i(in_valid[2]), .in_ready_o(ir2), .in_data_i(in_data[2]),
        .out_valid_o(ov2), .out_ready_i(out_ready[2]), .out_data_o(od2),
        .out_round_o(or2), .out_last_o(ol2));
    sha2_message_schedule_stream #(.MODE(512)) u_512 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .in_valid_i(in_valid[3]), .in_ready_o(ir3), .in_data_i(in_data[3]),
        .out_valid_o(ov3), .out_ready_i(out_ready[3]), .out_data_o(od3),
        .out_round_o(or3), .out_last_o(ol3));

    assign in_ready_w[0] = ir0;  assign in_ready_w[1] = ir1;
    assign in_ready_w[2] = ir2;  assign in_ready_w[3] = ir3;
    assign out_valid_w[0] = ov0; assign out_valid_w[1] = ov1;
    assign out_valid_w[2] = ov2; assign out_valid_w[3] = ov3;
    assign out_last_w[0] = ol0;  assign out_last_w[1] = ol1;
    assign out_last_w[2] = ol2;  assign out_last_w[3] = ol3;
    assign out_data_w[0] = {32'b0, od0};
    assign out_data_w[1] = {32'b0, od1};
    assign out_data_w[2] = od2;
    assign out_data_w[3] = od3;
    assign out_round_w[0] = {1'b0, or0};
    assign out_round_w[1] = {1'b0, or1};
    assign out_round_w[2] = or2;
    assign out_round_w[3] = or3;

    int          checks = 0;
    int          errors = 0;
    int          act    = 0;
    bit          mon_en = 1'b0;
    exp_t        exp_q [$];
    logic [63:0] cap   [80];
    logic [63:0] blk_w [16];
    logic [63:0] wexp  [80];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] rr(input logic [63:0] x, input int n, input int wd);
        logic [31:0] x32;
        x32 = x[31:0];
        if (wd == 32) return {32'b0, (x32 >> n) | (x32 << (32 - n))};
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] bs0(input logic [63:0] x, input int wd);
        if (wd == 32) return rr(x, 7, 32) ^ rr(x, 18, 32) ^ (x >> 3);
        return rr(x, 1, 64) ^ rr(x, 8, 64) ^ (x >> 7);
    endfunction

    function automatic logic [63:0] bs1(input logic [63:0] x, input int wd);
        if (wd == 32) return rr(x, 17, 32) ^ rr(x, 19, 32) ^ (x >> 10);
        return rr(x, 19, 64) ^ rr(x, 61, 64) ^ (x >> 6);
    endfunction

    // Textbook recurrence over a flat array, W_t = s1(W_{t-2}) + W_{t-7} + s0(W_{t-15}) + W_{t-16}.
    task automatic model(input int wd, input int nr);
        logic [63:0] v;
        for (int t = 0; t < 16; t++) wexp[t] = blk_w[t];
        for (int t = 16; t < nr; t++) begin
            v = bs1(wexp[t-2], wd) + wexp[t-7] + bs0(wexp[t-15], wd) + wexp[t-16];
            if (wd == 32) v = v & 64'h0000_0000_FFFF_FFFF;
            wexp[t] = v;
        end
        for (int t = 0; t < nr; t++) exp_q.push_back('{d: wexp[t], r: 7'(t), l: (t == nr - 1)});
    endtask

    task automatic gen_block(input int wd, input bit abc);
        for (int i = 0; i < 16; i++) begin
            if (abc) blk_w[i] = 64'h0;
            else if (wd == 32) blk_w[i] = {32'b0, $urandom};
            else blk_w[i] = {$urandom, $urandom};
        end
        if (abc) begin
            blk_w[0]  = (wd == 32) ? 64'h0000_0000_6162_6380 : 64'h6162_6380_0000_0000;
            blk_w[15] = 64'h18;
        end
    endtask

    // Output monitor: scoreboard pops on handshakes, stall stability while out_ready is low.
    bit          hold_v = 1'b0;
    logic [63:0] hold_d;
    logic [6:0]  hold_r;
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && rst_n && !clear) begin
            if (out_valid_w[act]) begin
                if (hold_v) begin
                    chk("stall_data", out_data_w[act], hold_d);
                    chk("stall_round", {57'b0, out_round_w[act]}, {57'b0, hold_r});
                end
                if (out_ready[act]) begin
                    hold_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("spurious_out", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data", out_data_w[act], e.d);
                        chk("round", {57'b0, out_round_w[act]}, {57'b0, e.r});
                        chk("last", {63'b0, out_last_w[act]}, {63'b0, e.l});
                        cap[e.r] = out_data_w[act];
                    end
                end else begin
                    hold_v = 1'b1;
                    hold_d = out_data_w[act];
                    hold_r = out_round_w[act];
                end
            end else begin
                if (hold_v) chk("valid_dropped", {63'b0, out_valid_w[act]}, 64'd1);
                hold_v = 1'b0;
            end
        end else begin
            hold_v = 1'b0;
        end
    end

    // Feed nblk blocks into DUT d with in_valid/out_ready probabilities (percent).
    // Optional one-shot events: clear at load word clr_in, clear at emit round clr_out,
    // one-cycle reset at emit round rst_at (-1 disables).
    task automatic run(input int d, input int nblk, input int pin, input int pout,
                       input bit abc, input int clr_in, input int clr_out, input int rst_at,
                       output int cycles);
        int wd     = (d < 2) ? 32 : 64;
        int nr     = (d < 2) ? 64 : 80;
        int budget = nblk * (16 + nr) * 10 + 400;
        int blk    = 0;
        int w      = 0;
        int cyc    = 0;
        bit need_new = 1'b1;
        bit ev_done  = 1'b0;
        bit post_clr = 1'b0;
        bit post_rst = 1'b0;
        act    = d;
        mon_en = 1'b1;
        while (1) begin
            @(posedge clk); #1;
            clear = 1'b0;
            rst_n = 1'b1;
            if (post_clr || post_rst) begin
                chk("abort_in_ready", {63'b0, in_ready_w[d]}, 64'd1);
                chk("abort_out_valid", {63'b0, out_valid_w[d]}, 64'd0);
                chk("abort_out_round", {57'b0, out_round_w[d]}, 64'd0);
            end
            if (post_rst) begin
                chk("rst_out_data", out_data_w[d], 64'd0);
                chk("rst_out_last", {63'b0, out_last_w[d]}, 64'd0);
                if (d == 1) begin
                    for (int i = 0; i < 16; i++) chk("rst_m_zero", {32'b0, u_256.m_q[i]}, 64'd0);
                end
            end
            post_clr = 1'b0;
            post_rst = 1'b0;
            if (blk == nblk && exp_q.size() == 0) begin
                chk("in_ready_after_last", {63'b0, in_ready_w[d]}, 64'd1);
                break;
            end
            if (cyc >= budget) begin
                chk("timeout_pending", 64'(exp_q.size() + (nblk - blk)), 64'd0);
                break;
            end
            cyc++;
            if (need_new && w == 0) begin
                gen_block(wd, abc);
                need_new = 1'b0;
            end
            in_valid[d]  = (blk < nblk) && ($urandom_range(99) < pin);
            in_data[d]   = blk_w[w];
            out_ready[d] = ($urandom_range(99) < pout);
            if (!ev_done && clr_in >= 0 && w == clr_in && in_ready_w[d]) begin
                clear = 1'b1; in_valid[d] = 1'b1; ev_done = 1'b1; post_clr = 1'b1;
            end
            if (!ev_done && clr_out >= 0 && out_valid_w[d] && out_round_w[d] == 7'(clr_out)) begin
                clear = 1'b1; out_ready[d] = 1'b1; ev_done = 1'b1; post_clr = 1'b1;
            end
            if (!ev_done && rst_at >= 0 && out_valid_w[d] && out_round_w[d] == 7'(rst_at)) begin
                rst_n = 1'b0; out_ready[d] = 1'b1; ev_done = 1'b1; post_rst = 1'b1;
            end
            @(negedge clk);
            if (clear || !rst_n) begin
                w = 0;
                if (exp_q.size() > 0) begin
                    exp_q.delete();
                    blk--;
                end
            end else if (in_valid[d] && in_ready_w[d]) begin
                w++;
                if (w == 16) begin
                    model(wd, nr);
                    blk++;
                    w = 0;
                    need_new = 1'b1;
                end
            end
        end
        in_valid[d]  = 1'b0;
        out_ready[d] = 1'b0;
        clear        = 1'b0;
        rst_n        = 1'b1;
        mon_en       = 1'b0;
        cycles       = cyc;
    endtask

    initial begin
        int cyc;
        rst_n = 1'b0;
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            in_data[i]   = 64'h0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("reset_in_ready", {63'b0, in_ready_w[i]}, 64'd1);
            chk("reset_out_valid", {63'b0, out_valid_w[i]}, 64'd0);
            chk("reset_out_data", out_data_w[i], 64'd0);
            chk("reset_out_round", {57'b0, out_round_w[i]}, 64'd0);
            chk("reset_out_last", {63'b0, out_last_w[i]}, 64'd0);
        end

        run(1, 1, 100, 100, 1'b1, -1, -1, -1, cyc);
        chk("abc256_w16", cap[16], 64'h6162_6380);
        chk("abc256_w17", cap[17], 64'h000F_0000);
        chk("abc256_period", 64'(cyc), 64'd80);

        run(3, 1, 100, 100, 1'b1, -1, -1, -1, cyc);
        chk("abc512_w16", cap[16], 64'h6162_6380_0000_0000);
        chk("abc512_period", 64'(cyc), 64'd96);

        run(1, 3, 100, 100, 1'b0, -1, -1, -1, cyc);
        chk("b2b256_cycles", 64'(cyc), 64'd240);
        run(3, 3, 100, 100, 1'b0, -1, -1, -1, cyc);
        chk("b2b512_cycles", 64'(cyc), 64'd288);

        run(0, 50, 70, 70, 1'b0, -1, -1, -1, cyc);
        run(2, 50, 70, 70, 1'b0, -1, -1, -1, cyc);

        run(1, 2, 100, 100, 1'b0, 7, -1, -1, cyc);
        run(1, 2, 100, 100, 1'b0, -1, 30, -1, cyc);
        run(3, 2, 80, 80, 1'b0, -1, 30, -1, cyc);
        run(1, 2, 100, 100, 1'b0, -1, -1, 20, cyc);
        run(1, 1, 100, 100, 1'b1, -1, -1, -1, cyc);
        chk("post_rst_abc_w17", cap[17], 64'h000F_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha2_message_schedule_stream.md
# sha2_message_schedule_stream

Streaming, mode-parametrised SHA-2 message-schedule engine with valid/ready handshakes on both sides. It accepts one 16-word message block, then emits the full expanded schedule W_0..W_{R-1}, one word per handshake, with round index and last-word flag. R = 64 for SHA-224/256 and R = 80 for SHA-384/512. It sits between the padding/block-assembly stage and the compression round datapath of the SHA-2 core used by the EdDSA engine. It adds flow control, a round counter and a block-abort control.

## Interface
- MODE, 256: 224, 256, 384 or 512. Fixes WIDTH (32 for 224/256, 64 for 384/512), ROUNDS (64 or 80) and the sigma functions. Any other value is illegal.
- WIDTH, derived localparam, not overridable.
- RW, derived localparam: $clog2(ROUNDS), the width of out_round.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- clear  in  1  synchronous block abort; returns the block to the LOAD state.
- in_valid  in  1  in_data holds a message word.
- in_ready  out  1  block accepts a message word this cycle.
- in_data  in  WIDTH  message word, big-endian word order, W_0 first.
- out_valid  out  1  out_data holds schedule word W_t.
- out_ready  in  1  consumer takes W_t this cycle.
- out_data  out  WIDTH  schedule word W_t.
- out_round  out  RW  index t of out_data.
- out_last  out  1  high when out_valid is high and t == ROUNDS-1.

## Operation
- Storage: 16-entry shift register M[0..15] of WIDTH bits. A shift moves M[i] <= M[i+1] for i < 15 and loads M[15] from the insert source.
- Expansion: new = M[0] + s0(M[1]) + M[9] + s1(M[14]), modulo 2^WIDTH.
  - 32-bit: s0 = ROTR7 ^ ROTR18 ^ SHR3; s1 = ROTR17 ^ ROTR19 ^ SHR10.
  - 64-bit: s0 = ROTR1 ^ ROTR8 ^ SHR7; s1 = ROTR19 ^ ROTR61 ^ SHR6.
- State machine: two states, LOAD and EMIT. Counter cnt is RW bits.
- LOAD:
  - in_ready = 1, out_valid = 0.
  - On an input handshake (in_valid & in_ready): shift with M[15] <= in_data, then cnt++.
  - On the handshake at cnt == 15: cnt <= 0, go to EMIT.
- EMIT:
  - in_ready = 0, out_valid = 1, out_data = M[0], out_round = cnt.
  - On an output handshake (out_valid & out_ready): shift with M[15] <= new, then cnt++.
  - On the handshake at cnt == ROUNDS-1: cnt <= 0, go to LOAD.
  - Words computed beyond W_{ROUNDS-1} are discarded.
- Stall: while out_ready = 0 in EMIT, M, cnt and all outputs hold. out_data stays stable while out_valid is high.
- Priority: rst, then clear, then handshakes.
  - clear in any state: cnt <= 0, state <= LOAD, M is not required to clear.
  - A handshake in the same cycle as clear is dropped. The word is not counted and not consumed.
- Reset values: state LOAD, cnt 0, M all zero. Outputs after reset: in_ready 1, out_valid 0, out_data 0, out_round 0, out_last 0.
- Reset mid-block: any partially loaded or partially emitted block is discarded. The next block restarts at W_0.

## Timing
- Control outputs (in_ready, out_valid, out_round, out_last) are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.
- out_valid rises in the cycle after the 16th input handshake.
- Throughput: one word per cycle on each side with no bubbles. The minimum block period is 16 + ROUNDS cycles (80 or 96).
- in_ready rises in the cycle after the out_last handshake. The next block's W_0 can be accepted in that cycle.
- The critical path is one 4-operand WIDTH-bit adder plus the sigma XOR logic, and must close at the core clock.

## Test plan
- MODE=256, message "abc" (W_0=0x61626380, W_1..W_14=0, W_15=0x00000018), out_ready=1 -> W_16=0x61626380, W_17=0x000F0000, W_0..W_63 match the golden model, out_last only at out_round=63, in_ready=1 in the following cycle.
- MODE=512, "abc" (W_0=0x6162638000000000, W_15=0x18) -> W_16=0x6162638000000000, 80 words emitted, out_last at out_round=79.
- Random in_valid/out_ready backpressure over 100 random blocks, MODE=224 and 384 -> no word lost or duplicated, out_data stable during stalls, every word matches the model.
- clear asserted at load word 7, and again at emit round 30, each with a simultaneous handshake -> handshake ignored, in_ready=1 and out_valid=0 next cycle, the following block is correct from W_0.
- rst pulsed low for 1 cycle mid-EMIT -> all outputs equal reset values next cycle, M all zero, the next block is correct.
- Back-to-back blocks with in_valid held high -> exactly 16+ROUNDS cycles per block, no bubble at the block boundary.
